spi_master: RTL and testbench

- Byte-wide SPI master that generates ss, sck and serial data for the beamScanner SPI_slave link, so it sits directly upstream of SPI_slave.
- SPI mode matches the slave: ss is active low, sck idles high, data changes on sck falling edges and is sampled on sck rising edges. Bit order is selectable per transfer.
- Full duplex: one byte goes out on sdout while one byte is captured from sdin into rdata. The system clock is divided down to sck by a programmable divider.

---
 rtl/spi_master.sv | 129 ++++++++++++
 tb/tb_spi_master.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// Byte-wide SPI master (ss active low, sck idles high, shift on fall, sample on rise).
// Optional SPI_MASTER_CS_GAP_EN keeps busy high for 2H clks after ss deasserts.
module spi_master #(
  parameter int DWIDTH = 8,
  parameter int CDIV_W = 8
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              start,
  input  logic              mlb,
  input  logic [CDIV_W-1:0] cdiv,
  input  logic [DWIDTH-1:0] tdata,
  input  logic              sdin,
  output logic              ss,
  output logic              sck,
  output logic              sdout,
  output logic              busy,
  output logic              done,
  output logic [DWIDTH-1:0] rdata
);

  localparam int BW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DWIDTH - 1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t            state, state_nxt;
  logic              go;
  logic              mlb_q;
  logic [CDIV_W-1:0] cdiv_q;
  logic [CDIV_W-1:0] cnt;
  logic [DWIDTH-1:0] tx;
  logic [DWIDTH-1:0] rx;
  logic [BW-1:0]     bit_cnt;
  logic [CDIV_W+1:0] gap_cnt;
  logic              phase_end;

  // cnt runs 0..cdiv_q, so a full-scale cdiv still yields 2^CDIV_W clks per phase.
  assign phase_end = (cnt == cdiv_q);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = SETUP;
      SETUP:   if (phase_end) state_nxt = XFER;
      XFER:    if (phase_end && !sck && bit_cnt == LAST_BIT) state_nxt = HOLD;
      HOLD:    if (phase_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      go      <= 1'b0;
      mlb_q   <= 1'b0;
      cdiv_q  <= '0;
      cnt     <= '0;
      tx      <= '0;
      rx      <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      ss      <= 1'b1;
      sck     <= 1'b1;
      sdout   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= '0;
    end else begin
      done <= 1'b0;
      cnt  <= (state == IDLE || phase_end) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: begin
          if (go) begin
            go      <= 1'b0;
            busy    <= 1'b1;
            ss      <= 1'b0;
            sdout   <= mlb_q ? tx[DWIDTH-1] : tx[0];
            tx      <= mlb_q ? (tx << 1) : (tx >> 1);
            bit_cnt <= '0;
          end else if (busy) begin
            // Done cycle (and optional deselect gap) before start is honoured again.
            if (gap_cnt == '0) busy <= 1'b0;
            else               gap_cnt <= gap_cnt - 1'b1;
          end else if (start) begin
            go     <= 1'b1;
            tx     <= tdata;
            mlb_q  <= mlb;
            cdiv_q <= cdiv;
          end
        end
        SETUP: begin
          if (phase_end) sck <= 1'b0;
        end
        XFER: begin
          if (phase_end) begin
            if (!sck) begin
              sck <= 1'b1;
              rx  <= mlb_q ? {rx[DWIDTH-2:0], sdin} : {sdin, rx[DWIDTH-1:1]};
              if (bit_cnt != LAST_BIT) bit_cnt <= bit_cnt + 1'b1;
            end else begin
              sck   <= 1'b0;
              sdout <= mlb_q ? tx[DWIDTH-1] : tx[0];
              tx    <= mlb_q ? (tx << 1) : (tx >> 1);
            end
          end
        end
        HOLD: begin
          if (phase_end) begin
            ss    <= 1'b1;
            done  <= 1'b1;
            rdata <= rx;
`ifdef SPI_MASTER_CS_GAP_EN
            gap_cnt <= {1'b0, cdiv_q, 1'b0} + (CDIV_W+2)'(2);
`else
            gap_cnt <= '0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: scoreboard of rdata and sdout bits, sck phase timing,
// abort-by-reset, ignored restart, back-to-back (gap checked when SPI_MASTER_CS_GAP_EN is set).
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       start = 1'b0;
  logic       mlb = 1'b1;
  logic [7:0] cdiv = '0;
  logic [7:0] tdata = '0;
  logic       sdin;
  logic       ss, sck, sdout, busy, done;
  logic [7:0] rdata;

  logic       loop_en = 1'b0;
  logic       slave_bit = 1'b0;
  logic       slave_seq[$];
  logic [7:0] exp_q[$];
  logic       bit_q[$];
  logic       mon_en = 1'b0;
  logic       prev_ss = 1'b1;
  logic       prev_sck = 1'b1;
  int         run = 0;
  int         exp_h = 1;
  int         rise_cnt = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  assign sdin = loop_en ? sdout : slave_bit;

  spi_master #(.DWIDTH(8), .CDIV_W(8)) dut (
    .clk(clk), .rstb(rstb), .start(start), .mlb(mlb), .cdiv(cdiv), .tdata(tdata),
    .sdin(sdin), .ss(ss), .sck(sck), .sdout(sdout), .busy(busy), .done(done), .rdata(rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave model: presents its next bit on every sck fall.
  always @(negedge sck) begin
    if (rstb && !ss && slave_seq.size() > 0) slave_bit = slave_seq.pop_front();
  end

  // Monitor: rdata on done, sdout on each sck rise, every sck phase length while selected.
  always @(negedge clk) begin
    if (mon_en) begin
      if (done) begin
        if (exp_q.size() == 0) check("rdata_unexpected_done", 32'(rdata), 32'hFFFF_FFFF);
        else check("rdata", 32'(rdata), 32'(exp_q.pop_front()));
      end
      if (sck && !prev_sck && !ss) begin
        rise_cnt++;
        if (bit_q.size() == 0) check("extra_sck_rise", 32'(rise_cnt), 32'(0));
        else check("sdout_bit", 32'(sdout), 32'(bit_q.pop_front()));
      end
      if (!ss && prev_ss) begin
        run = 1;
      end else if (!ss && sck != prev_sck) begin
        check("sck_phase_len", 32'(run), 32'(exp_h));
        run = 1;
      end else if (ss && !prev_ss) begin
        check("hold_phase_len", 32'(run), 32'(exp_h));
        check("sck_idle_high", 32'(sck), 32'(1));
      end else begin
        run++;
      end
    end else begin
      rise_cnt = 0;
    end
    prev_ss  = ss;
    prev_sck = sck;
  end

  task automatic load_expect(input logic [7:0] td, input logic m, input logic [7:0] sb,
                             input logic lp);
    for (int i = 0; i < 8; i++) begin
      bit_q.push_back(m ? td[7-i] : td[i]);
      slave_seq.push_back(m ? sb[7-i] : sb[i]);
    end
    exp_q.push_back(lp ? td : sb);
  endtask

  // One transfer; restart != 0 pulses start again at that edge number.
  task automatic run_xfer(input logic [7:0] td, input logic m, input logic [7:0] cd,
                          input logic [7:0] sb, input logic lp, input int restart);
    int n;
    int exp_len;
    logic last_bit;
    exp_len  = 1 + 17 * (int'(cd) + 1);
    exp_h    = int'(cd) + 1;
    last_bit = m ? td[0] : td[7];
    loop_en  = lp;
    slave_seq.delete();
    rise_cnt = 0;
    load_expect(td, m, sb, lp);
    @(negedge clk);
    start = 1'b1; tdata = td; mlb = m; cdiv = cd;
    n = 0;
    while (n < exp_len + 20) begin
      @(negedge clk);
      start = (restart != 0 && n + 1 == restart);
      if (n == 1) begin
        tdata = ~td; mlb = ~m; cdiv = 8'd7;
      end
      if (n == 0) check("busy_after_edge0", 32'(busy), 32'(0));
      if (n == 1) begin
        check("busy_edge1", 32'(busy), 32'(1));
        check("ss_edge1", 32'(ss), 32'(0));
      end
      if (done) break;
      n++;
    end
    start = 1'b0;
    check("done_edge", 32'(n), 32'(exp_len));
    @(negedge clk);
    check("done_one_clk", 32'(done), 32'(0));
`ifdef SPI_MASTER_CS_GAP_EN
    check("busy_in_gap", 32'(busy), 32'(1));
`else
    check("busy_after_done", 32'(busy), 32'(0));
`endif
    check("sdout_hold", 32'(sdout), 32'(last_bit));
    check("bits_left", 32'(bit_q.size()), 32'(0));
    for (int i = 0; i < 600 && busy; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("sck_idle_after", 32'(sck), 32'(1));
    check("bits_extra", 32'(rise_cnt), 32'(8));
  endtask

  task automatic reset_abort();
    int k;
    mon_en  = 1'b0;
    loop_en = 1'b0;
    @(negedge clk);
    start = 1'b1; tdata = 8'h3C; mlb = 1'b1; cdiv = 8'd0;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    for (int i = 0; i < 40 && k < 3; i++) begin
      @(negedge clk);
      if (sck && !prev_sck) k++;
    end
    check("abort_reached_rise3", 32'(k), 32'(3));
    rstb = 1'b0;
    #1;
    check("abort_ss", 32'(ss), 32'(1));
    check("abort_sck", 32'(sck), 32'(1));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    check("abort_rdata", 32'(rdata), 32'(0));
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    exp_q.delete(); bit_q.delete(); slave_seq.delete();
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  task automatic back_to_back();
    int n;
    int bh;
    int d;
    exp_h   = 2;
    loop_en = 1'b1;
    rise_cnt = 0;
    load_expect(8'h96, 1'b0, 8'h00, 1'b1);
    load_expect(8'h96, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    start = 1'b1; tdata = 8'h96; mlb = 1'b0; cdiv = 8'd1;
    d = 0;
    for (int i = 0; i < 80 && !done; i++) @(negedge clk);
    check("b2b_first_done", 32'(done), 32'(1));
    n = 0; bh = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (!ss) break;
      if (busy) bh++;
    end
    start = 1'b0;
`ifdef SPI_MASTER_CS_GAP_EN
    check("b2b_ss_gap", 32'(n), 32'(7));
    check("b2b_busy_in_gap", 32'(bh), 32'(4));
`else
    check("b2b_ss_gap", 32'(n), 32'(3));
    check("b2b_busy_in_gap", 32'(bh), 32'(0));
`endif
    for (int i = 0; i < 80 && !done; i++) @(negedge clk);
    check("b2b_second_done", 32'(done), 32'(1));
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("b2b_bits_left", 32'(bit_q.size()), 32'(0));
    check("b2b_rises", 32'(rise_cnt), 32'(16));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ss", 32'(ss), 32'(1));
    check("rst_sck", 32'(sck), 32'(1));
    check("rst_sdout", 32'(sdout), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_rdata", 32'(rdata), 32'(0));
    rstb = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    run_xfer(8'h7C, 1'b1, 8'd0, 8'h55, 1'b0, 0);
    run_xfer(8'h70, 1'b0, 8'd0, 8'h55, 1'b0, 0);
    run_xfer(8'hC3, 1'b1, 8'd3, 8'h9A, 1'b0, 0);
    run_xfer(8'h81, 1'b0, 8'd0, 8'h3E, 1'b0, 5);
    run_xfer(8'h3C, 1'b1, 8'd255, 8'hA6, 1'b0, 0);
    reset_abort();
    run_xfer(8'hA5, 1'b1, 8'd0, 8'h00, 1'b1, 0);
    back_to_back();
    check("exp_q_drained", 32'(exp_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
